// File: rtl/vga_if.sv
// Pixel-side bundle of the VGA timing generator: run enable and colour in,
// stage-0 coordinates, stage-1 syncs, colour and line/frame markers out.
interface vga_if #(
    parameter int COLOR_W = 8,
    parameter int H_W     = 10,
    parameter int V_W     = 10
);
    logic               en;
    logic [COLOR_W-1:0] color_in;
    logic [H_W-1:0]     pixel_x;
    logic [V_W-1:0]     pixel_y;
    logic               pixel_tick;
    logic               hsync;
    logic               vsync;
    logic               active;
    logic [COLOR_W-1:0] color_out;
    logic               line_start;
    logic               frame_start;

    // master = timing generator, slave = pixel source / DAC side.
    // No handshake: the generator paces everything with pixel_tick, and the
    // pixel source must hold color_in stable from one tick to the next.
    modport master (
        input  en, color_in,
        output pixel_x, pixel_y, pixel_tick, hsync, vsync, active,
        output color_out, line_start, frame_start
    );

    modport slave (
        output en, color_in,
        input  pixel_x, pixel_y, pixel_tick, hsync, vsync, active,
        input  color_out, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA timing generator: clock divider, x/y counters (stage 0)
// and a one-pixel register stage (stage 1) so colour lines up with the syncs.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int COLOR_W  = 8,
    parameter int H_W      = 10,
    parameter int V_W      = 10
) (
    input logic   clk,
    input logic   rst,
    vga_if.master vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (H_TOTAL - 1 >= (1 << H_W)) begin : g_h_overflow
        $error("vga_timing_gen: H_TOTAL-1 does not fit in H_W bits");
    end
    if (V_TOTAL - 1 >= (1 << V_W)) begin : g_v_overflow
        $error("vga_timing_gen: V_TOTAL-1 does not fit in V_W bits");
    end
    if (CLK_DIV < 1) begin : g_div_range
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0]   div_cnt;
    logic [H_W-1:0]     x;
    logic [V_W-1:0]     y;
    logic               tick;
    logic               x_last;
    logic               y_last;
    logic               visible;
    logic               hs_on;
    logic               vs_on;

    logic               hsync_q;
    logic               vsync_q;
    logic               active_q;
    logic [COLOR_W-1:0] color_q;
    logic               line_start_q;
    logic               frame_start_q;

    // Divider only moves while enabled, so a paused frame resumes mid-pixel.
    assign tick = vif.en && (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (vif.en) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    always_comb begin
        x_last  = (int'(x) == H_TOTAL - 1);
        y_last  = (int'(y) == V_TOTAL - 1);
        visible = (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE);
        hs_on   = (int'(x) >= H_ACTIVE + H_FP) && (int'(x) < H_ACTIVE + H_FP + H_SYNC);
        vs_on   = (int'(y) >= V_ACTIVE + V_FP) && (int'(y) < V_ACTIVE + V_FP + V_SYNC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (tick) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // Stage 1: everything the DAC sees is registered from the same stage-0 pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            active_q      <= 1'b0;
            color_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= tick && (x == '0);
            frame_start_q <= tick && (x == '0) && (y == '0);
            if (tick) begin
                hsync_q  <= hs_on ? H_POL : ~H_POL;
                vsync_q  <= vs_on ? V_POL : ~V_POL;
                active_q <= visible;
                color_q  <= visible ? vif.color_in : '0;
            end
        end
    end

    assign vif.pixel_x     = x;
    assign vif.pixel_y     = y;
    assign vif.pixel_tick  = tick;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.active      = active_q;
    assign vif.color_out   = color_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a tiny CLK_DIV=1 instance driven from a vector table
// and a default 640x480 instance walked pixel by pixel over whole lines.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  vga_if #(.COLOR_W(8), .H_W(10), .V_W(10)) a_if ();
  vga_if #(.COLOR_W(8), .H_W(4),  .V_W(3))  b_if ();

  vga_timing_gen dut_a (
    .clk (clk),
    .rst (rst_a),
    .vif (a_if)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .H_POL(1'b1), .V_POL(1'b1),
    .COLOR_W(8), .H_W(4), .V_W(3)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .vif (b_if)
  );

  // The default instance's pixel source returns the low byte of its x coordinate.
  assign a_if.color_in = a_if.pixel_x[7:0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- small instance: vector table ----------------
  localparam int NB = 150;
  typedef struct {
    logic        rst;
    logic        en;
    logic [7:0]  color;
    logic [20:0] exp;  // {x[3:0], y[2:0], tick, hsync, vsync, active, color[7:0], ls, fs}
  } vec_t;
  vec_t tbl[NB];

  task automatic fill_table();
    int p = 0;
    int q = 0;
    bit s1v = 0;
    bit fresh = 0;
    logic [7:0] cq = '0;
    for (int i = 0; i < NB; i++) begin
      logic r, e, hs, vs, act, ls, fs;
      logic [7:0] c, col;
      int xq, yq;
      r  = (i >= 90 && i < 92);
      e  = !r && !(i >= 60 && i < 65);
      c  = 8'(i * 37 + 5);
      xq = q % 8;
      yq = q / 8;
      hs = s1v && xq >= 5 && xq < 7;
      vs = s1v && yq == 4;
      act = s1v && xq < 4 && yq < 3;
      col = act ? cq : 8'h00;
      ls = fresh && s1v && xq == 0;
      fs = ls && yq == 0;
      tbl[i] = '{r, e, c, {4'(p % 8), 3'(p / 8), e, hs, vs, act, col, ls, fs}};
      if (r) begin
        p = 0; s1v = 0; fresh = 0;
      end else if (e) begin
        q = p; cq = c; s1v = 1; fresh = 1; p = (p + 1) % 48;
      end else begin
        fresh = 0;
      end
    end
  endtask

  // ---------------- default instance: line walker ----------------
  task automatic walk_line(input int y1, input int drop_at, input int drop_len,
                           output int len, output int hs_low, output int hs_lag);
    int xs = 0;
    int ph = 0;
    int px_seen = -1;
    int hs_seen = -1;
    bit fresh = 1;
    len = -1;
    hs_low = 0;
    for (int c = 0; c < 4000; c++) begin
      logic e, tk, hs, act, ls, fs;
      logic [7:0] col;
      logic [33:0] av, ev;
      int x0, y0;
      e   = !(c >= drop_at && c < drop_at + drop_len);
      x0  = (xs + 1) % 800;
      y0  = (xs == 799) ? y1 + 1 : y1;
      tk  = e && ph == 3;
      hs  = !(xs >= 656 && xs < 752);
      act = xs < 640 && y1 < 480;
      col = act ? 8'(xs) : 8'h00;
      ls  = fresh && xs == 0;
      fs  = ls && y1 == 0;
      ev  = {10'(x0), 10'(y0), tk, hs, 1'b1, act, col, ls, fs};
      av  = {a_if.pixel_x, a_if.pixel_y, a_if.pixel_tick, a_if.hsync, a_if.vsync,
             a_if.active, a_if.color_out, a_if.line_start, a_if.frame_start};
      check("line_walk", 64'(av), 64'(ev));
      if (a_if.hsync === 1'b0) hs_low++;
      if (px_seen < 0 && a_if.pixel_x == 10'd656) px_seen = c;
      if (hs_seen < 0 && a_if.hsync === 1'b0) hs_seen = c;
      fresh = 0;
      if (e) begin
        if (ph == 3) begin
          ph = 0; xs = (xs + 1) % 800; fresh = 1;
        end else begin
          ph++;
        end
      end
      @(negedge clk);
      a_if.en = !((c + 1) >= drop_at && (c + 1) < drop_at + drop_len);
      #1;
      if (fresh && xs == 0) begin
        len = c + 1;
        break;
      end
    end
    hs_lag = hs_seen - px_seen;
  endtask

  task automatic wait_frame_start(input string name);
    int n = 0;
    int hs_low = 0;
    bit seen = 0;
    while (n < 20) begin
      @(negedge clk);
      #1;
      n++;
      if (a_if.hsync === 1'b0) hs_low++;
      if (a_if.frame_start === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: frame_start not seen within 20 clk", name);
    end else begin
      check({name, "_latency"}, 64'(n), 64'd4);
      check({name, "_no_runt_hsync"}, 64'(hs_low), 64'd0);
    end
  endtask

  initial begin
    int len, hs_low, hs_lag;

    // Clock/reset block
    rst_a = 1'b1;
    rst_b = 1'b1;
    a_if.en = 1'b1;
    b_if.en = 1'b0;
    b_if.color_in = '0;
    fill_table();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_a", 64'({a_if.pixel_x, a_if.pixel_y, a_if.hsync, a_if.vsync, a_if.active,
                          a_if.color_out, a_if.line_start, a_if.frame_start}),
          64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}));
    check("reset_b", 64'({b_if.pixel_x, b_if.pixel_y, b_if.hsync, b_if.vsync, b_if.active,
                          b_if.color_out, b_if.line_start, b_if.frame_start}),
          64'({4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}));

    // Small instance: table vectors, with an en pause and a mid-frame reset.
    @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      rst_b = tbl[i].rst;
      b_if.en = tbl[i].en;
      b_if.color_in = tbl[i].color;
      #1;
      check($sformatf("vec%0d", i),
            64'({b_if.pixel_x, b_if.pixel_y, b_if.pixel_tick, b_if.hsync, b_if.vsync,
                 b_if.active, b_if.color_out, b_if.line_start, b_if.frame_start}),
            64'(tbl[i].exp));
      @(negedge clk);
    end
    b_if.en = 1'b0;

    // Default instance: release reset, first frame_start after 4 clk.
    rst_a = 1'b0;
    wait_frame_start("first_frame");

    walk_line(0, 1 << 30, 0, len, hs_low, hs_lag);
    check("line0_period", 64'(len), 64'd3200);
    check("line0_hsync_low", 64'(hs_low), 64'd384);
    check("line0_hsync_lag", 64'(hs_lag), 64'd4);

    walk_line(1, 1001, 37, len, hs_low, hs_lag);
    check("line1_period_en_drop", 64'(len), 64'd3237);
    check("line1_hsync_low", 64'(hs_low), 64'd384);
    check("line1_hsync_lag", 64'(hs_lag), 64'd4);

    // Reset in the middle of an hsync pulse on line 2.
    repeat (2800) @(negedge clk);
    #1;
    check("pre_reset_hsync", 64'(a_if.hsync), 64'd0);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    check("mid_reset_values", 64'({a_if.pixel_x, a_if.pixel_y, a_if.hsync, a_if.vsync,
                                   a_if.active, a_if.color_out, a_if.line_start,
                                   a_if.frame_start}),
          64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}));
    wait_frame_start("after_reset");

    walk_line(0, 1 << 30, 0, len, hs_low, hs_lag);
    check("post_reset_period", 64'(len), 64'd3200);
    check("post_reset_hsync_low", 64'(hs_low), 64'd384);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
